// File: rtl/accumulator_pkg.sv
// accumulator_pkg
// Shared definitions for the accumulator bank: the fill/drain state encoding,
// the beat mode constants and the saturating signed add used by every lane.
// No ports; imported by accumulator_bank and acc_lane.
package accumulator_pkg;

   typedef enum logic {
      FILL  = 1'b0,
      DRAIN = 1'b1
   } state_t;

   localparam logic MODE_OVERWRITE = 1'b0;
   localparam logic MODE_ACCUM     = 1'b1;

   // Arithmetic is done at a fixed wide width so one function serves every
   // accumulator width; accW selects the clamp range.
   localparam int SAT_CALC_W = 64;

   // Signed add of two wide operands, clamped to the range of an accW-bit
   // signed value.
   function automatic logic signed [SAT_CALC_W-1:0] sat_add(
      input logic signed [SAT_CALC_W-1:0] a,
      input logic signed [SAT_CALC_W-1:0] b,
      input int                           accW
   );
      logic signed [SAT_CALC_W-1:0] sum;
      logic signed [SAT_CALC_W-1:0] hi;
      logic signed [SAT_CALC_W-1:0] lo;
      sum = a + b;
      hi  = (64'sd1 <<< (accW - 1)) - 64'sd1;
      lo  = -(64'sd1 <<< (accW - 1));
      if (sum > hi) begin
         return hi;
      end else if (sum < lo) begin
         return lo;
      end
      return sum;
   endfunction

   // True when the same add would leave the accW-bit signed range.
   function automatic logic sat_ovf(
      input logic signed [SAT_CALC_W-1:0] a,
      input logic signed [SAT_CALC_W-1:0] b,
      input int                           accW
   );
      logic signed [SAT_CALC_W-1:0] sum;
      logic signed [SAT_CALC_W-1:0] hi;
      logic signed [SAT_CALC_W-1:0] lo;
      sum = a + b;
      hi  = (64'sd1 <<< (accW - 1)) - 64'sd1;
      lo  = -(64'sd1 <<< (accW - 1));
      return (sum > hi) || (sum < lo);
   endfunction

endpackage

// File: rtl/accumulator_bank_lane.sv
// acc_lane
// Datapath for one lane of the accumulator bank: computes the next stored
// value for the row being written, either the sign-extended input
// (overwrite) or the saturating sum with the current contents (accumulate).
// Ports:
//   i_mode  - 0 overwrite, 1 accumulate
//   i_data  - signed lane input, DATA_W bits
//   i_acc   - current stored lane value, ACC_W bits
//   o_next  - value to store, ACC_W bits
//   o_sat   - the accumulate result was clamped
module acc_lane
   import accumulator_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ACC_W  = 16
) (
   input  logic              i_mode,
   input  logic [DATA_W-1:0] i_data,
   input  logic [ACC_W-1:0]  i_acc,
   output logic [ACC_W-1:0]  o_next,
   output logic              o_sat
);

   logic signed [SAT_CALC_W-1:0] w_dataExt;
   logic signed [SAT_CALC_W-1:0] w_accExt;

   assign w_dataExt = SAT_CALC_W'(signed'(i_data));
   assign w_accExt  = SAT_CALC_W'(signed'(i_acc));

   // Overwrite never saturates since ACC_W is at least DATA_W; the clamp
   // flag only matters for accumulate beats.
   always_comb begin
      o_next = ACC_W'(w_dataExt);
      o_sat  = 1'b0;
      if (i_mode == MODE_ACCUM) begin
         o_next = ACC_W'(sat_add(w_accExt, w_dataExt, ACC_W));
         o_sat  = sat_ovf(w_accExt, w_dataExt, ACC_W);
      end
   end

endmodule

// File: rtl/accumulator_bank.sv
// accumulator_bank
// Multi-lane output buffer for the systolic array. Rows of array outputs are
// written (overwrite or saturating accumulate) into a DEPTH-row buffer; once
// the final pass of a tile lands in the last row, the rows are drained
// through a valid/ready port.
// Ports:
//   clk, reset (async, active-low), clear (sync flush)
//   in_valid/in_ready/in_mode/in_last/in_data - input beat, lane 0 in LSBs
//   out_valid/out_ready/out_data/out_row      - drain row, lane 0 in LSBs
//   full - tile complete and draining; sat - sticky saturation flag
module accumulator_bank
   import accumulator_pkg::*;
#(
   parameter int LANES  = 2,
   parameter int DATA_W = 8,
   parameter int ACC_W  = 16,
   parameter int DEPTH  = 2,
   localparam int IDX_W = $clog2(DEPTH)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    clear,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    in_mode,
   input  logic                    in_last,
   input  logic [LANES*DATA_W-1:0] in_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [LANES*ACC_W-1:0]  out_data,
   output logic [IDX_W-1:0]        out_row,
   output logic                    full,
   output logic                    sat
);

   localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(DEPTH - 1);

   state_t                   r_state;
   state_t                   w_nextState;
   logic [IDX_W-1:0]         r_wrIdx;
   logic [IDX_W-1:0]         r_rdIdx;
   logic [LANES*ACC_W-1:0]   r_mem [DEPTH];
   logic                     r_sat;
   logic [LANES*ACC_W-1:0]   w_rowNext;
   logic [LANES-1:0]         w_laneSat;
   logic                     w_accept;
   logic                     w_drainHs;

   // One datapath per lane, all reading the row currently being written.
   for (genvar g = 0; g < LANES; g++) begin : g_lane
      acc_lane #(
         .DATA_W(DATA_W),
         .ACC_W (ACC_W)
      ) u_lane (
         .i_mode(in_mode),
         .i_data(in_data[g*DATA_W +: DATA_W]),
         .i_acc (r_mem[r_wrIdx][g*ACC_W +: ACC_W]),
         .o_next(w_rowNext[g*ACC_W +: ACC_W]),
         .o_sat (w_laneSat[g])
      );
   end

   // clear wins over any handshake, so neither a write nor a drain step
   // happens in a clearing cycle.
   assign w_accept  = in_valid && in_ready && !clear;
   assign w_drainHs = out_valid && out_ready && !clear;

   // State register; clear forces a return to FILL.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= FILL;
      end else if (clear) begin
         r_state <= FILL;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state and handshake outputs. A tile completes only when in_last
   // arrives on the beat that writes the last row.
   always_comb begin
      w_nextState = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      full        = 1'b0;
      case (r_state)
         FILL: begin
            in_ready = 1'b1;
            if (in_valid && in_last && (r_wrIdx == LAST_ROW)) begin
               w_nextState = DRAIN;
            end
         end
         DRAIN: begin
            out_valid = 1'b1;
            full      = 1'b1;
            if (out_ready && (r_rdIdx == LAST_ROW)) begin
               w_nextState = FILL;
            end
         end
         default: w_nextState = FILL;
      endcase
   end

   // Buffer, indexes and sticky saturation flag. The buffer is deliberately
   // kept on drain exit; the next tile starts with an overwrite pass.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int r = 0; r < DEPTH; r++) begin
            r_mem[r] <= '0;
         end
         r_wrIdx <= '0;
         r_rdIdx <= '0;
         r_sat   <= 1'b0;
      end else if (clear) begin
         for (int r = 0; r < DEPTH; r++) begin
            r_mem[r] <= '0;
         end
         r_wrIdx <= '0;
         r_rdIdx <= '0;
         r_sat   <= 1'b0;
      end else begin
         if (w_accept) begin
            r_mem[r_wrIdx] <= w_rowNext;
            r_wrIdx        <= (r_wrIdx == LAST_ROW) ? '0 : r_wrIdx + 1'b1;
            if (|w_laneSat) begin
               r_sat <= 1'b1;
            end
            if (in_last && (r_wrIdx == LAST_ROW)) begin
               r_rdIdx <= '0;
            end
         end
         if (w_drainHs) begin
            if (r_rdIdx == LAST_ROW) begin
               r_rdIdx <= '0;
               r_wrIdx <= '0;
            end else begin
               r_rdIdx <= r_rdIdx + 1'b1;
            end
         end
      end
   end

   assign out_data = r_mem[r_rdIdx];
   assign out_row  = r_rdIdx;
   assign sat      = r_sat;

endmodule

// File: tb/tb_accumulator_bank.sv
// tb_accumulator_bank
// Drives two accumulator banks in lockstep (ACC_W=16 and ACC_W=8) so the
// same beats show both the wide result and the clamped narrow result.
// Expected rows are pushed to a scoreboard when a tile's final beat is
// driven and popped as the DUTs drain.
module tb_accumulator_bank;

   logic        clk = 1'b0;
   logic        reset;
   logic        clear;
   logic        in_valid;
   logic        in_mode;
   logic        in_last;
   logic [15:0] in_data;
   logic        out_ready;

   logic        readyA, validA, fullA, satA;
   logic [31:0] dataA;
   logic        rowA;
   logic        readyB, validB, fullB, satB;
   logic [15:0] dataB;
   logic        rowB;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int row;
      int a0;
      int a1;
      int b0;
      int b1;
   } rowExp_t;

   rowExp_t expQ[$];
   int      memA[2][2];
   int      memB[2][2];
   int      mWr;
   bit      satExpA;
   bit      satExpB;

   accumulator_bank #(.LANES(2), .DATA_W(8), .ACC_W(16), .DEPTH(2)) dutA (
      .clk(clk), .reset(reset), .clear(clear),
      .in_valid(in_valid), .in_ready(readyA), .in_mode(in_mode),
      .in_last(in_last), .in_data(in_data),
      .out_valid(validA), .out_ready(out_ready), .out_data(dataA),
      .out_row(rowA), .full(fullA), .sat(satA)
   );

   accumulator_bank #(.LANES(2), .DATA_W(8), .ACC_W(8), .DEPTH(2)) dutB (
      .clk(clk), .reset(reset), .clear(clear),
      .in_valid(in_valid), .in_ready(readyB), .in_mode(in_mode),
      .in_last(in_last), .in_data(in_data),
      .out_valid(validB), .out_ready(out_ready), .out_data(dataB),
      .out_row(rowB), .full(fullB), .sat(satB)
   );

   always #5 clk = ~clk;

   // Clamp an integer to the signed range of a w-bit value.
   function automatic int clampTo(input int v, input int w);
      int hi;
      int lo;
      hi = (1 <<< (w - 1)) - 1;
      lo = -(1 <<< (w - 1));
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic modelReset();
      for (int r = 0; r < 2; r++) begin
         for (int l = 0; l < 2; l++) begin
            memA[r][l] = 0;
            memB[r][l] = 0;
         end
      end
      mWr     = 0;
      satExpA = 1'b0;
      satExpB = 1'b0;
      expQ.delete();
   endtask

   // Drive one accepted beat for a full cycle and update the model.
   task automatic applyStimulus(input logic mode, input logic last, input int d0, input int d1);
      int      d;
      int      s;
      rowExp_t e;
      in_valid = 1'b1;
      in_mode  = mode;
      in_last  = last;
      in_data  = {8'(d1), 8'(d0)};
      checkOutput("in_ready_fill", 64'(readyA), 64'd1);
      for (int l = 0; l < 2; l++) begin
         d = (l == 0) ? d0 : d1;
         if (mode) begin
            s = memA[mWr][l] + d;
            memA[mWr][l] = clampTo(s, 16);
            if (memA[mWr][l] != s) satExpA = 1'b1;
            s = memB[mWr][l] + d;
            memB[mWr][l] = clampTo(s, 8);
            if (memB[mWr][l] != s) satExpB = 1'b1;
         end else begin
            memA[mWr][l] = d;
            memB[mWr][l] = d;
         end
      end
      if (last && mWr == 1) begin
         for (int r = 0; r < 2; r++) begin
            e.row = r;
            e.a0  = memA[r][0];
            e.a1  = memA[r][1];
            e.b0  = memB[r][0];
            e.b1  = memB[r][1];
            expQ.push_back(e);
         end
      end
      mWr = (mWr + 1) % 2;
      @(posedge clk); #1;
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_in_ready"}, 64'(readyA), 64'd1);
      checkOutput({tag, "_out_valid"}, 64'(validA), 64'd0);
      checkOutput({tag, "_full"}, 64'(fullA), 64'd0);
      checkOutput({tag, "_sat"}, 64'(satA), 64'd0);
      checkOutput({tag, "_out_data"}, 64'(dataA), 64'd0);
      checkOutput({tag, "_out_row"}, 64'(rowA), 64'd0);
      checkOutput({tag, "_in_ready_b"}, 64'(readyB), 64'd1);
      checkOutput({tag, "_sat_b"}, 64'(satB), 64'd0);
      checkOutput({tag, "_out_data_b"}, 64'(dataB), 64'd0);
   endtask

   // Drain both rows with out_ready held high, comparing against the scoreboard.
   task automatic drainAll(input string tag);
      rowExp_t e;
      int      waitCycles;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      for (int r = 0; r < 2; r++) begin
         waitCycles = 0;
         while (!validA && waitCycles < 20) begin
            @(posedge clk); #1;
            waitCycles++;
         end
         checkOutput({tag, "_out_valid"}, 64'(validA), 64'd1);
         checkOutput({tag, "_sb_nonempty"}, 64'(expQ.size() != 0), 64'd1);
         if (expQ.size() == 0) break;
         e = expQ.pop_front();
         checkOutput({tag, "_out_row"}, 64'(rowA), 64'(e.row));
         checkOutput({tag, "_out_data"}, 64'(dataA), 64'({16'(e.a1), 16'(e.a0)}));
         checkOutput({tag, "_full"}, 64'(fullA), 64'd1);
         checkOutput({tag, "_in_ready_drain"}, 64'(readyA), 64'd0);
         checkOutput({tag, "_out_valid_b"}, 64'(validB), 64'd1);
         checkOutput({tag, "_out_row_b"}, 64'(rowB), 64'(e.row));
         checkOutput({tag, "_out_data_b"}, 64'(dataB), 64'({8'(e.b1), 8'(e.b0)}));
         if (r == 0) begin
            checkOutput({tag, "_sat"}, 64'(satA), 64'(satExpA));
            checkOutput({tag, "_sat_b"}, 64'(satB), 64'(satExpB));
         end
         @(posedge clk); #1;
      end
      out_ready = 1'b0;
      checkOutput({tag, "_in_ready_after"}, 64'(readyA), 64'd1);
      checkOutput({tag, "_full_after"}, 64'(fullA), 64'd0);
      checkOutput({tag, "_out_valid_after"}, 64'(validA), 64'd0);
   endtask

   initial begin
      reset     = 1'b0;
      clear     = 1'b0;
      in_valid  = 1'b0;
      in_mode   = 1'b0;
      in_last   = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      modelReset();

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      checkResetValues("reset");
      reset = 1'b1;
      @(posedge clk); #1;

      // Overwrite tile, including a zero lane value
      applyStimulus(1'b0, 1'b0, 3, 5);
      applyStimulus(1'b0, 1'b1, 7, 0);
      drainAll("ow");

      // Two passes: overwrite then accumulate
      applyStimulus(1'b0, 1'b0, 1, 2);
      applyStimulus(1'b0, 1'b0, 3, 4);
      applyStimulus(1'b1, 1'b0, 10, 20);
      applyStimulus(1'b1, 1'b1, 30, 40);
      drainAll("accum");

      // Saturation: clamps only in the 8-bit bank
      applyStimulus(1'b0, 1'b0, 100, -100);
      applyStimulus(1'b0, 1'b0, 0, 0);
      applyStimulus(1'b1, 1'b0, 100, -100);
      applyStimulus(1'b1, 1'b1, 0, 0);
      drainAll("sat");

      // Back-pressure: a beat offered during drain must not be taken
      applyStimulus(1'b0, 1'b0, 1, 1);
      applyStimulus(1'b0, 1'b1, 2, 2);
      in_valid  = 1'b1;
      in_mode   = 1'b0;
      in_last   = 1'b1;
      in_data   = {8'd9, 8'd9};
      out_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         checkOutput("stall_out_row", 64'(rowA), 64'(expQ[0].row));
         checkOutput("stall_out_data", 64'(dataA), 64'({16'(expQ[0].a1), 16'(expQ[0].a0)}));
         checkOutput("stall_in_ready", 64'(readyA), 64'd0);
         checkOutput("stall_out_valid", 64'(validA), 64'd1);
         @(posedge clk); #1;
      end
      drainAll("stall");

      // clear during drain with a beat and a drain handshake offered
      applyStimulus(1'b0, 1'b0, 5, 6);
      applyStimulus(1'b0, 1'b1, 7, 8);
      in_valid  = 1'b1;
      in_mode   = 1'b0;
      in_last   = 1'b0;
      in_data   = {8'd50, 8'd50};
      out_ready = 1'b1;
      clear     = 1'b1;
      @(posedge clk); #1;
      clear     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      modelReset();
      checkResetValues("clear");
      applyStimulus(1'b1, 1'b0, 1, 1);
      applyStimulus(1'b1, 1'b1, 2, 2);
      drainAll("after_clear");

      // Reset mid-fill discards the partial tile
      applyStimulus(1'b0, 1'b0, 4, 4);
      in_valid = 1'b0;
      #2;
      reset = 1'b0;
      #1;
      checkResetValues("reset_mid");
      @(posedge clk); #1;
      reset = 1'b1;
      modelReset();
      @(posedge clk); #1;
      applyStimulus(1'b0, 1'b0, 11, 12);
      applyStimulus(1'b0, 1'b1, 13, 14);
      drainAll("after_reset");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
